booth_mult_arbiter: RTL and testbench
=====================================

# booth_mult_arbiter

- Round-robin front-end that shares one 8×8 signed Booth multiplier between `NREQ` requesters.
- Latches the winning requester's operands and sequences the multiplier's load/run phases.
- Returns the 16-bit product to the winner with its ID over a valid/ready handshake.
- Sits between client blocks and the single `Booth_Multiplier` instance; it is that instance's only driver.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `WIDTH`, 8: operand width; product is `2*WIDTH`.
- `LOAD_CYCLES`, 2: cycles the multiplier is held in load before run, ≥1.
- `TIMEOUT`, 31: max RUN cycles before abort; only used with the watchdog macro.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req` in `NREQ`: per-requester request level.
- `a` in `NREQ*WIDTH`: packed multiplicands; requester i owns bits [i*WIDTH +: WIDTH].
- `b` in `NREQ*WIDTH`: packed multipliers, same packing.
- `gnt` out `NREQ`: one-hot, single-cycle grant pulse.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_id` out `$clog2(NREQ)`: index of the granted requester.
- `rsp_product` out `2*WIDTH`: signed product.
- `rsp_err` out 1: watchdog abort flag.
- `mul_multi` out `WIDTH`: to multiplier `multi`.
- `mul_multiplier` out `WIDTH`: to multiplier `multiplier`.
- `mul_load` out 1: to multiplier `rst`; 1 = load/hold, 0 = run.
- `mul_done` in 1: from multiplier `done`.
- `mul_product` in `2*WIDTH`: from multiplier `product`.

## Operation
- FSM states: IDLE, LOAD, RUN, RESP.
- Reset values:
  - state IDLE; `gnt`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_product`=0, `rsp_err`=0.
  - `mul_load`=1, `mul_multi`=0, `mul_multiplier`=0.
  - Round-robin pointer last=`NREQ-1`, so requester 0 has first priority.
- IDLE:
  - `mul_load`=1.
  - If `req`≠0, select the first set bit searching from last+1 with wrap-around.
  - Capture that requester's `a`/`b` into `mul_multi`/`mul_multiplier`, record `rsp_id`, update last, go to LOAD.
- LOAD:
  - `mul_load`=1 for exactly `LOAD_CYCLES` cycles.
  - `gnt[id]`=1 during the first LOAD cycle only.
  - Then go to RUN.
- RUN:
  - `mul_load`=0; `mul_done` is sampled only in this state.
  - On `mul_done`=1: capture `mul_product` into `rsp_product`, clear `rsp_err`, go to RESP.
- RESP:
  - `rsp_valid`=1 and `mul_load`=1; response fields hold stable.
  - On `rsp_valid && rsp_ready`: clear `rsp_valid`, go to IDLE.
- Operand registers are not changed outside the IDLE capture.
- Requesters hold `req` and operands until they see `gnt`, then may drop `req`.
  - A `req` still high in IDLE after its grant is a new request.
- `req` changes during LOAD/RUN/RESP are ignored until IDLE.
- Products are signed two's complement, `2*WIDTH` bits, passed through unmodified.

## Timing
- Request-to-grant: `req` sampled in IDLE at edge n; `gnt` high in cycle n+1.
- Request-to-response: `rsp_valid` rises at n+1+`LOAD_CYCLES`+R, where R is the RUN cycles until `mul_done`.
- Back-to-back requests:
  - After the response handshake, at least one IDLE cycle occurs before the next grant.
  - Throughput is one multiply per (`LOAD_CYCLES`+R+2) cycles with `rsp_ready` tied high.
- `rsp_ready` low stalls in RESP indefinitely; the multiplier stays in load.
- `rst` low at any time, mid-operation included:
  - All outputs take reset values immediately, asynchronously.
  - The in-flight response is discarded; no `gnt` replay.
- Simultaneous requests: exactly one grant per arbitration; no requester waits more than `NREQ-1` grants.

## Configuration
- `BOOTH_ARB_TIMEOUT_EN` defined:
  - A RUN-cycle counter is compiled in.
  - When the counter reaches `TIMEOUT` with `mul_done` still 0: go to RESP with `rsp_err`=1, `rsp_product`=0, same `rsp_id`.
- `BOOTH_ARB_TIMEOUT_EN` undefined:
  - No counter; RUN waits for `mul_done` indefinitely.
  - `rsp_err` is tied 0.

## Test plan
- Single requester: `req`=0001, a0=0xCB, b0=0x0E → `gnt`=0001 for 1 cycle; `rsp_valid`, `rsp_id`=0, `rsp_product`=0xFD1A (−742).
- Fairness: `req`=1111 held with 4 operand pairs, `rsp_ready`=1 → grant order 0,1,2,3,0. Sample products:
  - 0x0B×0x0E = 0x009A.
  - 0xEC×0xCC = 0x0410.
  - 0xFF×0xFE = 0x0002.
- Backpressure: `rsp_ready`=0 for 20 cycles while `req`=0010 pending → response held stable, no new `gnt`; release → next grant one cycle after IDLE.
- Reset mid-RUN: assert `rst`=0 during RUN → `rsp_valid`=0, `mul_load`=1, `gnt`=0 immediately; after release `req`=0100 is granted first-come from pointer 0.
- Watchdog (macro defined, `TIMEOUT`=31): force `mul_done`=0 → `rsp_valid` with `rsp_err`=1 and `rsp_product`=0x0000 after 31 RUN cycles. Macro undefined → no response within 200 cycles.

Source files
------------

// File: rtl/booth_mult_arbiter.sv
// booth_mult_arbiter
// Round-robin front-end sharing one WIDTHxWIDTH signed Booth multiplier between
// NREQ requesters. Latches the winner's operands, sequences the multiplier's
// load/run phases and returns the product with the winner's ID over valid/ready.
// Optional feature: define BOOTH_ARB_TIMEOUT_EN to compile in a RUN watchdog
// that aborts after TIMEOUT cycles with rsp_err=1 and a zero product.

module booth_mult_arbiter #(
    parameter int NREQ        = 4,
    parameter int WIDTH       = 8,
    parameter int LOAD_CYCLES = 2,
    parameter int TIMEOUT     = 31
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   a,
    input  logic [NREQ*WIDTH-1:0]   b,
    output logic [NREQ-1:0]         gnt,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [2*WIDTH-1:0]      rsp_product,
    output logic                    rsp_err,
    output logic [WIDTH-1:0]        mul_multi,
    output logic [WIDTH-1:0]        mul_multiplier,
    output logic                    mul_load,
    input  logic                    mul_done,
    input  logic [2*WIDTH-1:0]      mul_product
);

    localparam int IDW = $clog2(NREQ);
    localparam int LCW = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
    localparam logic [LCW-1:0] LC_LAST  = LCW'(LOAD_CYCLES - 1);
    localparam logic [IDW-1:0] LAST_RST = IDW'(NREQ - 1);
    localparam logic [IDW:0]   NREQ_W   = (IDW + 1)'(NREQ);

    // Elaboration-time parameter range check
    if (NREQ < 2 || NREQ > 8 || LOAD_CYCLES < 1 || TIMEOUT < 1) begin : g_bad_cfg
        $error("booth_mult_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        RESP
    } state_e;

    state_e state_q, state_d;

    logic [IDW-1:0]     last_q, last_d;
    logic [IDW-1:0]     id_q, id_d;
    logic [WIDTH-1:0]   multi_q, multi_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [LCW-1:0]     load_cnt_q, load_cnt_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    logic               pick_valid;
    logic [IDW-1:0]     pick_id;
    logic [WIDTH-1:0]   pick_a;
    logic [WIDTH-1:0]   pick_b;
    logic               abort;

`ifdef BOOTH_ARB_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT + 1);

    logic [TCW-1:0] run_cnt_q, run_cnt_d;
    logic           err_q, err_d;

    // Watchdog next state: count RUN cycles, flag abort on the last allowed one
    always_comb begin
        run_cnt_d = (state_q == RUN) ? run_cnt_q + 1'b1 : '0;
        err_d     = err_q;
        if (state_q == RUN) begin
            if (mul_done) begin
                err_d = 1'b0;
            end else if (abort) begin
                err_d = 1'b1;
            end
        end
    end

    assign abort = (state_q == RUN) && !mul_done && (run_cnt_q == TCW'(TIMEOUT - 1));

    // Watchdog registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            run_cnt_q <= run_cnt_d;
            err_q     <= err_d;
        end
    end

    assign rsp_err = err_q;
`else
    assign abort   = 1'b0;
    assign rsp_err = 1'b0;
`endif

    // Round-robin pick: first set req bit searching from last+1 with wrap-around
    always_comb begin
        logic [IDW:0] idx;
        idx        = '0;
        pick_valid = 1'b0;
        pick_id    = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            idx = {1'b0, last_q} + (IDW + 1)'(i);
            if (idx >= NREQ_W) begin
                idx = idx - NREQ_W;
            end
            if (!pick_valid && req[idx[IDW-1:0]]) begin
                pick_valid = 1'b1;
                pick_id    = idx[IDW-1:0];
            end
        end
    end

    // Operand mux for the picked requester
    always_comb begin
        pick_a = '0;
        pick_b = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick_id == IDW'(i)) begin
                pick_a = a[i*WIDTH +: WIDTH];
                pick_b = b[i*WIDTH +: WIDTH];
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (pick_valid) state_d = LOAD;
            LOAD: if (load_cnt_q == LC_LAST) state_d = RUN;
            RUN:  if (mul_done || abort) state_d = RESP;
            RESP: if (rsp_valid && rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: grant pulse in first LOAD cycle, valid in RESP, multiplier runs only in RUN
    always_comb begin
        gnt       = '0;
        rsp_valid = 1'b0;
        mul_load  = 1'b1;
        case (state_q)
            LOAD: if (load_cnt_q == '0) gnt[id_q] = 1'b1;
            RUN:  mul_load = 1'b0;
            RESP: rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath next state: operands and ID only change on the IDLE capture
    always_comb begin
        last_d     = last_q;
        id_d       = id_q;
        multi_d    = multi_q;
        mplier_d   = mplier_q;
        load_cnt_d = load_cnt_q;
        product_d  = product_q;
        case (state_q)
            IDLE: begin
                load_cnt_d = '0;
                if (pick_valid) begin
                    last_d   = pick_id;
                    id_d     = pick_id;
                    multi_d  = pick_a;
                    mplier_d = pick_b;
                end
            end
            LOAD: load_cnt_d = load_cnt_q + 1'b1;
            RUN: begin
                if (mul_done) begin
                    product_d = mul_product;
                end else if (abort) begin
                    product_d = '0;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q     <= LAST_RST;
            id_q       <= '0;
            multi_q    <= '0;
            mplier_q   <= '0;
            load_cnt_q <= '0;
            product_q  <= '0;
        end else begin
            last_q     <= last_d;
            id_q       <= id_d;
            multi_q    <= multi_d;
            mplier_q   <= mplier_d;
            load_cnt_q <= load_cnt_d;
            product_q  <= product_d;
        end
    end

    assign rsp_id         = id_q;
    assign rsp_product    = product_q;
    assign mul_multi      = multi_q;
    assign mul_multiplier = mplier_q;

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Directed self-checking bench for booth_mult_arbiter, with a simple
// 3-cycle multiplier stand-in driven by the arbiter's mul_* outputs.
module tb_booth_mult_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] a_s;
    logic [NREQ*WIDTH-1:0] b_s;
    logic [NREQ-1:0]       gnt;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [1:0]            rsp_id;
    logic [15:0]           rsp_product;
    logic                  rsp_err;
    logic [7:0]            mul_multi;
    logic [7:0]            mul_multiplier;
    logic                  mul_load;
    logic                  mul_done;
    logic [15:0]           mul_product;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned cyc     = 0;

    logic        hang = 1'b0;
    logic [1:0]  mcnt = 2'd0;
    logic signed [15:0] ma, mb;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier stand-in: done on the third RUN cycle unless hung
    always @(posedge clk) begin
        if (mul_load) mcnt <= 2'd0;
        else if (mcnt != 2'd3) mcnt <= mcnt + 2'd1;
    end
    assign ma          = {{8{mul_multi[7]}}, mul_multi};
    assign mb          = {{8{mul_multiplier[7]}}, mul_multiplier};
    assign mul_product = ma * mb;
    assign mul_done    = !mul_load && (mcnt == 2'd2) && !hang;

    booth_mult_arbiter #(
        .NREQ(NREQ),
        .WIDTH(WIDTH),
        .LOAD_CYCLES(2),
        .TIMEOUT(31)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .a(a_s),
        .b(b_s),
        .gnt(gnt),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id(rsp_id),
        .rsp_product(rsp_product),
        .rsp_err(rsp_err),
        .mul_multi(mul_multi),
        .mul_multiplier(mul_multiplier),
        .mul_load(mul_load),
        .mul_done(mul_done),
        .mul_product(mul_product)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_gnt(input int bound, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (gnt != '0) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_valid(input int bound, output logic seen, output int n);
        seen = 1'b0;
        n    = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                seen = 1'b1;
                n    = i + 1;
                break;
            end
        end
    endtask

    int unsigned exp_id[5] = '{0, 1, 2, 3, 0};
    logic [15:0] exp_p[5]  = '{16'h009A, 16'h0410, 16'h0002, 16'hC080, 16'h009A};

    initial begin
        logic        seen;
        int          n;
        int unsigned last_cyc;
        int unsigned bad;

        last_cyc  = 0;
        rst       = 1'b0;
        req       = '0;
        a_s       = '0;
        b_s       = '0;
        rsp_ready = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_valid", 32'(rsp_valid), 32'h0);
        chk("rst_id", 32'(rsp_id), 32'h0);
        chk("rst_product", 32'(rsp_product), 32'h0);
        chk("rst_err", 32'(rsp_err), 32'h0);
        chk("rst_mul_load", 32'(mul_load), 32'h1);
        chk("rst_multi", 32'(mul_multi), 32'h0);
        chk("rst_multiplier", 32'(mul_multiplier), 32'h0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Single requester 0: 0xCB * 0x0E = 0xFD1A
        a_s[7:0]  = 8'hCB;
        b_s[7:0]  = 8'h0E;
        req       = 4'b0001;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("t1_gnt", 32'(gnt), 32'h1);
        chk("t1_multi", 32'(mul_multi), 32'hCB);
        chk("t1_multiplier", 32'(mul_multiplier), 32'h0E);
        chk("t1_load1", 32'(mul_load), 32'h1);
        req = '0;
        @(negedge clk);
        chk("t1_gnt_pulse", 32'(gnt), 32'h0);
        chk("t1_load2", 32'(mul_load), 32'h1);
        @(negedge clk);
        chk("t1_run", 32'(mul_load), 32'h0);
        repeat (2) @(negedge clk);
        chk("t1_not_valid_yet", 32'(rsp_valid), 32'h0);
        @(negedge clk);
        chk("t1_valid", 32'(rsp_valid), 32'h1);
        chk("t1_id", 32'(rsp_id), 32'h0);
        chk("t1_product", 32'(rsp_product), 32'h0000FD1A);
        chk("t1_err", 32'(rsp_err), 32'h0);
        @(negedge clk);
        chk("t1_idle_valid", 32'(rsp_valid), 32'h0);
        chk("t1_idle_gnt", 32'(gnt), 32'h0);

        // Fairness from reset: all four requesting, order 0,1,2,3,0
        rst = 1'b0;
        a_s = {8'h7F, 8'hFF, 8'hEC, 8'h0B};
        b_s = {8'h80, 8'hFE, 8'hCC, 8'h0E};
        req = 4'b1111;
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_gnt(20, seen);
            chk("rr_gnt_seen", 32'(seen), 32'h1);
            chk("rr_gnt", 32'(gnt), 32'h1 << exp_id[k]);
            if (k > 0) chk("rr_period", cyc - last_cyc, 32'd7);
            last_cyc = cyc;
            wait_valid(20, seen, n);
            chk("rr_valid_seen", 32'(seen), 32'h1);
            chk("rr_id", 32'(rsp_id), exp_id[k]);
            chk("rr_product", 32'(rsp_product), 32'(exp_p[k]));
            if (k == 4) req = '0;
        end
        @(negedge clk);

        // Backpressure: requester 1 stalled 20 cycles with its request still high
        rsp_ready = 1'b0;
        req       = 4'b0010;
        wait_gnt(20, seen);
        chk("bp_gnt_seen", 32'(seen), 32'h1);
        chk("bp_gnt", 32'(gnt), 32'h2);
        wait_valid(20, seen, n);
        chk("bp_valid_seen", 32'(seen), 32'h1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_product !== 16'h0410 ||
                gnt !== 4'b0000 || mul_load !== 1'b1) bad++;
        end
        chk("bp_stable", bad, 32'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_idle_valid", 32'(rsp_valid), 32'h0);
        chk("bp_idle_gnt", 32'(gnt), 32'h0);
        @(negedge clk);
        chk("bp_regrant", 32'(gnt), 32'h2);
        req = '0;
        wait_valid(20, seen, n);
        chk("bp2_valid_seen", 32'(seen), 32'h1);
        chk("bp2_product", 32'(rsp_product), 32'h0410);
        @(negedge clk);

        // Reset mid-RUN
        req = 4'b0001;
        wait_gnt(20, seen);
        chk("mr_gnt", 32'(gnt), 32'h1);
        req = '0;
        repeat (2) @(negedge clk);
        chk("mr_in_run", 32'(mul_load), 32'h0);
        #2 rst = 1'b0;
        #1;
        chk("mr_valid", 32'(rsp_valid), 32'h0);
        chk("mr_mul_load", 32'(mul_load), 32'h1);
        chk("mr_gnt0", 32'(gnt), 32'h0);
        chk("mr_multi", 32'(mul_multi), 32'h0);
        req = 4'b0100;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mr_first_gnt", 32'(gnt), 32'h4);
        req = '0;
        wait_valid(20, seen, n);
        chk("mr_valid_seen", 32'(seen), 32'h1);
        chk("mr_id", 32'(rsp_id), 32'h2);
        chk("mr_product", 32'(rsp_product), 32'h0002);
        @(negedge clk);

        // Watchdog: multiplier never finishes
        req = 4'b1000;
        wait_gnt(20, seen);
        chk("wd_gnt", 32'(gnt), 32'h8);
        hang = 1'b1;
        req  = '0;
        repeat (2) @(negedge clk);
        chk("wd_in_run", 32'(mul_load), 32'h0);
`ifdef BOOTH_ARB_TIMEOUT_EN
        wait_valid(60, seen, n);
        chk("wd_valid_seen", 32'(seen), 32'h1);
        chk("wd_run_cycles", 32'(n), 32'd31);
        chk("wd_err", 32'(rsp_err), 32'h1);
        chk("wd_product", 32'(rsp_product), 32'h0);
        chk("wd_id", 32'(rsp_id), 32'h3);
        hang = 1'b0;
        @(negedge clk);
`else
        wait_valid(200, seen, n);
        chk("wd_no_response", 32'(seen), 32'h0);
        chk("wd_still_run", 32'(mul_load), 32'h0);
        chk("wd_err_tied", 32'(rsp_err), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        rst  = 1'b1;
        hang = 1'b0;
`endif
        @(negedge clk);
        chk("end_idle_valid", 32'(rsp_valid), 32'h0);
        chk("end_idle_load", 32'(mul_load), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
